level_tile_fetcher: RTL and testbench

- Upstream neighbour of display_controller: converts the live VGA scan position (hCount, vCount) into the 3-bit blockType of the 32x32 tile under the beam.
- Owns the writable tile map (20x15 tiles) and the FSM that copies a level from level ROM into it on request.
- Accepts single-tile clears from game logic; clearing a tile writes air (0).

---
 rtl/tile_pkg.sv | 56 +++++
 rtl/level_rom.sv | 20 ++
 rtl/level_tile_fetcher.sv | 158 +++++++++++++++
 tb/tb_level_tile_fetcher.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile map path feeding display_controller.
// Holds the block IDs, the visible-area and tile geometry, the level loader
// FSM encoding, and the helpers that turn a (row, col) pair into a map
// index and that define the level ROM contents.
package tile_pkg;

  localparam int TILE_SIZE  = 32;
  localparam int H_START    = 144;
  localparam int V_START    = 35;
  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int TILE_COLS  = 20;
  localparam int TILE_ROWS  = 15;
  localparam int MAP_DEPTH  = TILE_COLS * TILE_ROWS;
  localparam int LEVEL_BITS = 2;

  typedef enum logic [2:0] {
    AIR        = 3'd0,
    FOREGROUND = 3'd1,
    HALF_SLAB  = 3'd2,
    DOOR       = 3'd3
  } block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  // row*20 + col built from shifts so no multiplier is needed.
  function automatic logic [8:0] tile_index(input logic [3:0] row,
                                            input logic [4:0] col);
    tile_index = {1'b0, row, 4'b0000} + {3'b000, row, 2'b00} + {4'b0000, col};
  endfunction

  // Level contents: a scrambled pattern per level, (idx + idx/8 + 3*level)
  // mod 4, with a few fixed landmarks in level 0 (top-left foreground,
  // half slab at col 5 row 2, door at the bottom-right tile). Entries past
  // the 300 used tiles read as air.
  function automatic logic [2:0] level_tile(input logic [1:0] level,
                                            input logic [8:0] idx);
    logic [1:0] mix;
    mix = idx[1:0] + idx[4:3] + {level[0], 1'b0} + level;
    if (idx >= 9'(MAP_DEPTH))
      level_tile = AIR;
    else if (level == 2'd0 && idx == 9'd0)
      level_tile = FOREGROUND;
    else if (level == 2'd0 && idx == 9'd45)
      level_tile = HALF_SLAB;
    else if (level == 2'd0 && idx == 9'd299)
      level_tile = DOOR;
    else
      level_tile = {1'b0, mix};
  endfunction

endpackage

// File: rtl/level_rom.sv
// Level ROM: 4 levels x 512 entries of 3-bit block IDs, synchronous read
// with one cycle of latency.
// Ports:
//   clk   - system clock
//   addr  - {level, tileIdx}, 11 bits
//   data  - block ID at addr, valid the cycle after addr is presented
module level_rom
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [2:0]  data
);

  // Registered read; the contents are a fixed table so no reset is needed.
  always_ff @(posedge clk) begin
    data <= level_tile(addr[10:9], addr[8:0]);
  end

endmodule

// File: rtl/level_tile_fetcher.sv
// Converts the live VGA scan position into the block ID of the 32x32 tile
// under the beam, owns the writable 20x15 tile map, and copies a level from
// the level ROM into that map on request. Game logic may clear single tiles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   hCount, vCount    - current scan position
//   loadReq, levelId  - pulse to start loading level levelId
//   clearReq          - pulse to clear the tile at (clearCol, clearRow)
//   clearCol/Row      - tile coordinates to clear
//   loadBusy          - high while the map is being (re)loaded
//   loadDone          - one-cycle pulse when a load completes
//   blockType         - block ID under the beam, two cycles after hCount/vCount
module level_tile_fetcher
  import tile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hCount,
  input  logic [9:0]            vCount,
  input  logic                  loadReq,
  input  logic [LEVEL_BITS-1:0] levelId,
  input  logic                  clearReq,
  input  logic [4:0]            clearCol,
  input  logic [3:0]            clearRow,
  output logic                  loadBusy,
  output logic                  loadDone,
  output logic [2:0]            blockType
);

  logic [2:0] map_ram [0:511];

  fetch_state_t          state;
  logic [8:0]            load_addr;
  logic [LEVEL_BITS-1:0] level_q;
  logic                  pend_valid;
  logic [8:0]            pend_addr;
  logic [2:0]            rom_data;

  logic [9:0] h_off;
  logic [9:0] v_off;
  logic       in_field;
  logic [8:0] scan_idx;
  logic       in_field_q;
  logic [8:0] idx_q;

  logic       clear_ok;
  logic [8:0] clear_idx;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [2:0] wr_data;

  level_rom u_rom (
    .clk  (clk),
    .addr ({level_q, load_addr}),
    .data (rom_data)
  );

  // Below-start positions wrap to large offsets, but the lower-bound compare
  // already rejects them, so the wrapped offset never reaches the index.
  assign h_off    = hCount - 10'(H_START);
  assign v_off    = vCount - 10'(V_START);
  assign in_field = (hCount >= 10'(H_START)) && (h_off < 10'(H_VISIBLE)) &&
                    (vCount >= 10'(V_START)) && (v_off < 10'(V_VISIBLE));
  assign scan_idx = tile_index(v_off[8:5], h_off[9:5]);

  // Stage 1: register field membership and the tile index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_field_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      in_field_q <= in_field;
      idx_q      <= scan_idx;
    end
  end

  // Stage 2: map read. Nonblocking semantics give old data when the same
  // address is written on this edge. The map is hidden while it is reloading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blockType <= AIR;
    else if (in_field_q && !loadBusy)
      blockType <= map_ram[idx_q];
    else
      blockType <= AIR;
  end

  assign clear_ok  = (clearCol < 5'(TILE_COLS)) && (clearRow < 4'(TILE_ROWS));
  assign clear_idx = tile_index(clearRow, clearCol);

  // Single write port: the delayed ROM write of a load has priority; clears
  // are only possible in IDLE, when no ROM write is pending, and a load
  // request in the same cycle suppresses the clear.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pend_addr;
    wr_data = rom_data;
    if (pend_valid) begin
      wr_en = 1'b1;
    end else if (state == ST_IDLE && clearReq && !loadReq && clear_ok) begin
      wr_en   = 1'b1;
      wr_addr = clear_idx;
      wr_data = AIR;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      map_ram[wr_addr] <= wr_data;
  end

  // Loader FSM. LOAD issues one ROM read per cycle; the data comes back a
  // cycle later and is written to the address remembered in pend_addr.
  // FLUSH exists only to retire the write for the last address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      load_addr  <= '0;
      level_q    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      loadBusy   <= 1'b1;
      loadDone   <= 1'b0;
    end else begin
      loadDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          pend_valid <= 1'b0;
          if (loadReq) begin
            level_q   <= levelId;
            load_addr <= '0;
            loadBusy  <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pend_valid <= 1'b1;
          pend_addr  <= load_addr;
          load_addr  <= load_addr + 9'd1;
          if (load_addr == 9'(MAP_DEPTH - 1))
            state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          pend_valid <= 1'b0;
          loadDone   <= 1'b1;
          loadBusy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          pend_valid <= 1'b0;
          loadBusy   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_tile_fetcher.sv
// Self-checking bench for level_tile_fetcher: boot load, scan lookups from a
// vector table, tile clears, a level load with ignored mid-load requests,
// and a reset in the middle of a load. Scan expectations travel through a
// queue and are compared when the two-cycle pipeline delivers blockType.
module tb_level_tile_fetcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       loadReq;
  logic [1:0] levelId;
  logic       clearReq;
  logic [4:0] clearCol;
  logic [3:0] clearRow;
  logic       loadBusy;
  logic       loadDone;
  logic [2:0] blockType;

  level_tile_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .hCount    (hCount),
    .vCount    (vCount),
    .loadReq   (loadReq),
    .levelId   (levelId),
    .clearReq  (clearReq),
    .clearCol  (clearCol),
    .clearRow  (clearRow),
    .loadBusy  (loadBusy),
    .loadDone  (loadDone),
    .blockType (blockType)
  );

  initial forever #5 clk = ~clk;

  // Rising edges seen so far; scoreboard entries are due two edges after
  // the negedge that drove them.
  int posCount = 0;
  always @(posedge clk) posCount <= posCount + 1;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int         due;
    logic [2:0] exp;
    string      name;
  } sbEntry_t;
  sbEntry_t sbQueue[$];

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[13];

  logic [2:0] mapModel [0:299];

  task automatic checkOutput(input string name, input int got, input int exp);
    checkCount++;
    if (got == exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Level contents as the game designers describe them.
  function automatic logic [2:0] romModel(input int lvl, input int idx);
    if (lvl == 0 && idx == 0)   return 3'd1;
    if (lvl == 0 && idx == 45)  return 3'd2;
    if (lvl == 0 && idx == 299) return 3'd3;
    return 3'((idx + idx / 8 + 3 * lvl) % 4);
  endfunction

  task automatic mapLevel(input int lvl);
    for (int i = 0; i < 300; i++) mapModel[i] = romModel(lvl, i);
  endtask

  // Pop every expectation whose pipeline slot has arrived.
  always @(negedge clk) begin : sbMonitor
    sbEntry_t e;
    while (sbQueue.size() != 0 && sbQueue[0].due <= posCount) begin
      e = sbQueue.pop_front();
      checkOutput(e.name, int'(blockType), int'(e.exp));
    end
  end

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic [2:0] exp, input string name);
    @(negedge clk);
    hCount = h;
    vCount = v;
    sbQueue.push_back('{due: posCount + 2, exp: exp, name: name});
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  task automatic scanMap(input string name);
    for (int i = 0; i < 300; i++) begin
      int col;
      int row;
      col = i % 20;
      row = i / 20;
      applyStimulus(10'(144 + col * 32 + (i * 7) % 32),
                    10'(35 + row * 32 + (i * 13) % 32),
                    mapModel[i], $sformatf("%s tile %0d", name, i));
    end
  endtask

  // Called right after the negedge where the load was started (loadReq
  // raised or reset released). Counts busy cycles up to loadDone, optionally
  // injects a clear and a second load mid-way, and optionally scans the map
  // expecting air while busy.
  task automatic waitLoadDone(input int expBusy, input string name,
                              input int clearAt, input int reloadAt,
                              input bit scanDuring);
    int busyCycles = 0;
    int donePulses = 0;
    int busyAfter  = 0;
    bit seen       = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(negedge clk);
      loadReq  = 1'b0;
      clearReq = 1'b0;
      if (loadDone) begin
        seen = 1'b1;
        donePulses++;
        checkOutput({name, " busy at done"}, loadBusy, 0);
      end else if (loadBusy) begin
        busyCycles++;
      end
      if (!seen) begin
        if (i == clearAt) begin
          clearReq = 1'b1;
          clearCol = 5'd5;
          clearRow = 4'd2;
        end
        if (i == reloadAt) begin
          loadReq = 1'b1;
          levelId = 2'd2;
        end
        if (scanDuring && i <= 290) begin
          int t;
          t = i % 300;
          hCount = 10'(144 + (t % 20) * 32 + 5);
          vCount = 10'(35 + (t / 20) * 32 + 9);
          sbQueue.push_back('{due: posCount + 2, exp: 3'd0,
                              name: $sformatf("%s blockType while busy %0d", name, i)});
        end
      end
    end
    checkOutput({name, " load finished"}, seen, 1);
    checkOutput({name, " busy cycles"}, busyCycles, expBusy);
    repeat (5) begin
      @(negedge clk);
      if (loadDone) donePulses++;
      if (loadBusy) busyAfter++;
    end
    checkOutput({name, " done pulses"}, donePulses, 1);
    checkOutput({name, " busy after done"}, busyAfter, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{10'd144, 10'd35,  3'd1};
    vecs[1]  = '{10'd783, 10'd514, 3'd3};
    vecs[2]  = '{10'd100, 10'd35,  3'd0};
    vecs[3]  = '{10'd144, 10'd20,  3'd0};
    vecs[4]  = '{10'd335, 10'd99,  3'd2};
    vecs[5]  = '{10'd336, 10'd99,  3'd3};
    vecs[6]  = '{10'd783, 10'd35,  3'd1};
    vecs[7]  = '{10'd784, 10'd35,  3'd0};
    vecs[8]  = '{10'd144, 10'd515, 3'd0};
    vecs[9]  = '{10'd143, 10'd35,  3'd0};
    vecs[10] = '{10'd144, 10'd67,  3'd2};
    vecs[11] = '{10'd176, 10'd35,  3'd1};
    vecs[12] = '{10'd560, 10'd300, 3'd2};

    rst      = 1'b1;
    hCount   = '0;
    vCount   = '0;
    loadReq  = 1'b0;
    levelId  = '0;
    clearReq = 1'b0;
    clearCol = '0;
    clearRow = '0;

    // Reset state, then the automatic level-0 boot load.
    repeat (3) @(negedge clk);
    checkOutput("reset loadBusy", loadBusy, 1);
    checkOutput("reset loadDone", loadDone, 0);
    checkOutput("reset blockType", blockType, 0);
    rst = 1'b0;
    waitLoadDone(300, "boot", -1, -1, 1'b0);
    mapLevel(0);

    // Table-driven scan lookups, back to back through the pipeline.
    for (int i = 0; i < 13; i++)
      applyStimulus(vecs[i].h, vecs[i].v, vecs[i].exp, $sformatf("vector %0d", i));
    drain();

    // One in-range clear, then an out-of-range column that would alias
    // onto tile 20 if the range check were missing.
    @(negedge clk);
    clearReq = 1'b1;
    clearCol = 5'd5;
    clearRow = 4'd2;
    mapModel[45] = 3'd0;
    @(negedge clk);
    clearCol = 5'd20;
    clearRow = 4'd0;
    @(negedge clk);
    clearReq = 1'b0;
    applyStimulus(10'd335, 10'd99, mapModel[45], "cleared tile 45");
    applyStimulus(10'd336, 10'd99, mapModel[46], "neighbour tile 46");
    applyStimulus(10'd150, 10'd70, mapModel[20], "tile 20 after bad clear");
    drain();

    // Level 1 load with a clear and a second load request issued mid-load.
    @(negedge clk);
    loadReq = 1'b1;
    levelId = 2'd1;
    waitLoadDone(301, "level1", 200, 100, 1'b1);
    drain();
    mapLevel(1);
    scanMap("level1");
    drain();

    // Reset while a level-2 load is half way through.
    @(negedge clk);
    loadReq = 1'b1;
    levelId = 2'd2;
    repeat (151) begin
      @(negedge clk);
      loadReq = 1'b0;
    end
    checkOutput("level2 busy before reset", loadBusy, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid-load reset loadBusy", loadBusy, 1);
    checkOutput("mid-load reset loadDone", loadDone, 0);
    checkOutput("mid-load reset blockType", blockType, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitLoadDone(300, "reload after reset", -1, -1, 1'b0);
    mapLevel(0);
    scanMap("after reset");
    drain();

    checkOutput("scoreboard drained", sbQueue.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
